cla_seq_adder32: RTL and testbench

Multi-cycle wide adder that drives the team's 8-bit carry-lookahead adder (`cla_8bit`) one byte slice per clock, chaining the slice carry through a register. It sits directly upstream of the `cla_8bit` core: it feeds the core's operands and carry-in and consumes its sum and carry-out. This gives a WIDTH-bit add at 8-bit area cost. It is the datapath used wherever a wide add can tolerate WIDTH/8 cycles of latency.

---
 rtl/cla_seq_adder32.sv | 187 ++++++++++++++++++
 tb/tb_cla_seq_adder32.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder32.sv
// Sequential WIDTH-bit adder that reuses one 8-bit carry-lookahead slice per clock.
// Optional subtract mode is enabled by defining CLA_SEQ_SUB_EN.

module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       acc;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is formed directly from generate/propagate terms, not rippled.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    c[0] = carry_in;
    for (int i = 0; i < 8; i++) begin
      acc      = p[i];
      c[i + 1] = g[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i + 1] = c[i + 1] | (g[j] & acc);
        acc      = acc & p[j];
      end
      c[i + 1] = c[i + 1] | (carry_in & acc);
    end
  end

  assign sum       = p ^ c[7:0];
  assign carry_out = c[8];

endmodule

module cla_seq_adder32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSLICE = WIDTH / 8;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned MSB    = WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [7:0]       slice_a;
  logic [7:0]       slice_b;
  logic [7:0]       slice_sum;
  logic             slice_cout;

`ifdef CLA_SEQ_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = cin ^ sub;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif

  // Select the operand byte addressed by the slice index.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int s = 0; s < int'(NSLICE); s++) begin
      if (idx_q == IDX_W'(s)) begin
        slice_a = a_q[8*s +: 8];
        slice_b = b_q[8*s +: 8];
      end
    end
  end

  cla_8bit u_cla (
    .a         (slice_a),
    .b         (slice_b),
    .carry_in  (c_q),
    .sum       (slice_sum),
    .carry_out (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_eff;
          c_d     = c_eff;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int s = 0; s < int'(NSLICE); s++) begin
          if (idx_q == IDX_W'(s)) sum_d[8*s +: 8] = slice_sum;
        end
        c_d = slice_cout;
        // Flags come from the final slice directly, as they are latched with it.
        if (idx_q == IDX_W'(NSLICE - 1)) begin
          state_d = S_DONE;
          cout_d  = slice_cout;
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (slice_sum[7] != a_q[MSB]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder32.sv
// Scoreboard bench for cla_seq_adder32: expected results are queued at issue
// and compared by a monitor whenever done pulses.

module tb_cla_seq_adder32;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cla_seq_adder32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", 64'(sum), 64'(e.sum));
        check("cout", 64'(cout), 64'(e.cout));
        check("ovf", 64'(ovf), 64'(e.ovf));
      end
    end
  end

  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic c,
                       input logic s);
    a = av;
    b = bv;
    cin = c;
    sub = s;
  endtask

  // Counts busy cycles until done; gives up after a bounded number of cycles.
  task automatic wait_done(output int nbusy);
    int guard;
    nbusy = 0;
    guard = 0;
    while (!done && guard < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      guard++;
    end
    check("done_seen", 64'(done), 64'(1));
  endtask

  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic c, input logic s, input logic [31:0] es,
                        input logic ec, input logic eo);
    int nb;
    @(negedge clk);
    drive(av, bv, c, s);
    start = 1'b1;
    exp_q.push_back('{sum: es, cout: ec, ovf: eo});
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    check({name, "_busy_cycles"}, 64'(nb), 64'(4));
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int nb;
    int gap;
    int ndone;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    rst_n = 1'b1;

    run_op("slice_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // A start pulse two cycles into RUN must not disturb the operation.
    @(negedge clk);
    drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    start = 1'b1;
    exp_q.push_back('{sum: 32'h2345_6789, cout: 1'b0, ovf: 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    @(negedge clk);

    // Back-to-back: start held high across RUN and DONE.
    drive(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);
    start = 1'b1;
    exp_q.push_back('{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0});
    @(negedge clk);
    drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    exp_q.push_back('{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1});
    wait_done(nb);
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_done_gap", 64'(gap), 64'(5));
    @(negedge clk);

    // Reset dropped with idx=2 mid-RUN.
    drive(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
    check("midrst_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'(0));

`ifdef CLA_SEQ_SUB_EN
    run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
